// File: rtl/ram_responder.sv
// Fixed-latency single-port word memory answering the ramstate_t handshake.
// Optional macro RAM_RESPONDER_PERF_EN adds saturating read/write/abort counters.
module ram_responder #(
   parameter int LAT    = 2,
   parameter int DEPTH  = 1024,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ren,
   input  logic              wen,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] store,
   output logic [1:0]        ramstate,
   output logic [WORD_W-1:0] load
`ifdef RAM_RESPONDER_PERF_EN
   ,
   output logic [31:0]       rd_cnt,
   output logic [31:0]       wr_cnt,
   output logic [15:0]       abort_cnt
`endif
);

   // Encodings equal the ramstate_t values so ramstate is the state register itself.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);
   localparam logic [3:0]      CNT_INIT = 4'(LAT - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                lat_ren_q, lat_ren_d;
   logic                lat_wen_q, lat_wen_d;
   logic [WORD_W-1:0]   lat_addr_q, lat_addr_d;
   logic [WORD_W-1:0]   lat_store_q, lat_store_d;
   logic [WORD_W-1:0]   load_q, load_d;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       idx;
   logic                req, bad, match, mem_we;
   logic                rd_ev, wr_ev, abort_ev;

   assign req   = ren | wen;
   assign bad   = (ren & wen) || (addr[1:0] != 2'b00) ||
                  ({2'b00, addr[WORD_W-1:2]} >= DEPTH_W);
   assign match = ({ren, wen, addr, store} ==
                    {lat_ren_q, lat_wen_q, lat_addr_q, lat_store_q});
   assign idx   = lat_addr_q[AW+1:2];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_ren_d   = lat_ren_q;
      lat_wen_d   = lat_wen_q;
      lat_addr_d  = lat_addr_q;
      lat_store_d = lat_store_q;
      load_d      = load_q;
      mem_we      = 1'b0;
      rd_ev       = 1'b0;
      wr_ev       = 1'b0;
      abort_ev    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (bad) begin
                  state_d = ERR;
               end else begin
                  state_d     = WAIT;
                  cnt_d       = CNT_INIT;
                  lat_ren_d   = ren;
                  lat_wen_d   = wen;
                  lat_addr_d  = addr;
                  lat_store_d = store;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d  = IDLE;
               abort_ev = 1'b1;
            end else if (!match) begin
               // A changed request restarts the full latency; an illegal one errors out.
               if (bad) begin
                  state_d = ERR;
               end else begin
                  cnt_d       = CNT_INIT;
                  lat_ren_d   = ren;
                  lat_wen_d   = wen;
                  lat_addr_d  = addr;
                  lat_store_d = store;
                  abort_ev    = 1'b1;
               end
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               if (lat_ren_q) begin
                  load_d = mem[idx];
                  rd_ev  = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  wr_ev  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         lat_ren_q   <= 1'b0;
         lat_wen_q   <= 1'b0;
         lat_addr_q  <= '0;
         lat_store_q <= '0;
         load_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_ren_q   <= lat_ren_d;
         lat_wen_q   <= lat_wen_d;
         lat_addr_q  <= lat_addr_d;
         lat_store_q <= lat_store_d;
         load_q      <= load_d;
      end
   end

   // Backing store survives reset; mem_we is dead while reset holds the FSM in IDLE.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[idx] <= lat_store_q;
   end

   assign ramstate = state_q;
   assign load     = load_q;

`ifdef RAM_RESPONDER_PERF_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] abort_cnt_q, abort_cnt_d;

   always_comb begin
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      abort_cnt_d = abort_cnt_q;
      if (rd_ev && (rd_cnt_q != '1))          rd_cnt_d    = rd_cnt_q + 32'd1;
      if (wr_ev && (wr_cnt_q != '1))          wr_cnt_d    = wr_cnt_q + 32'd1;
      if (abort_ev && (abort_cnt_q != '1))    abort_cnt_d = abort_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         abort_cnt_q <= '0;
      end else begin
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign abort_cnt = abort_cnt_q;
`else
   logic unused_ev;
   assign unused_ev = rd_ev ^ wr_ev ^ abort_ev;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed + randomized bench for ram_responder against an array-based memory model.
module tb_ram_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 1024;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   logic        CLK, nRST, ren, wen;
   logic [31:0] addr, store, load;
   logic [1:0]  ramstate;
`ifdef RAM_RESPONDER_PERF_EN
   logic [31:0] rd_cnt, wr_cnt;
   logic [15:0] abort_cnt;
`endif

   ram_responder #(.LAT(LAT), .DEPTH(DEPTH), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .store(store),
      .ramstate(ramstate), .load(load)
`ifdef RAM_RESPONDER_PERF_EN
      , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .abort_cnt(abort_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] load_exp = 32'd0;
   int          rd_n = 0, wr_n = 0, ab_n = 0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One held request: legal -> LAT BUSY then ACCESS; illegal -> one ERROR; then FREE.
   task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
      logic bad;
      int   wi;
      bad = (r && w) || (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
      wi  = int'(a[31:2]);
      ren = r; wen = w; addr = a; store = s;
      tick();
      if (bad) begin
         chk("err_state", {30'd0, ramstate}, {30'd0, ERROR});
      end else begin
         for (int i = 0; i < LAT; i++) begin
            chk("busy", {30'd0, ramstate}, {30'd0, BUSY});
            tick();
         end
         if (r) begin
            load_exp = model_mem[wi];
            rd_n++;
         end else begin
            model_mem[wi] = s;
            wr_n++;
         end
         chk("access", {30'd0, ramstate}, {30'd0, ACCESS});
      end
      chk("load_done", load, load_exp);
      ren = 1'b0; wen = 1'b0;
      tick();
      chk("free_after", {30'd0, ramstate}, {30'd0, FREE});
      chk("load_free", load, load_exp);
   endtask

   task automatic midop(input bit drop);
      ren = 1'b1; wen = 1'b0; addr = 32'h10; store = 32'd0;
      tick();
      chk("mid_busy0", {30'd0, ramstate}, {30'd0, BUSY});
      ab_n++;
      if (drop) begin
         ren = 1'b0;
         tick();
         chk("abort_free", {30'd0, ramstate}, {30'd0, FREE});
         tick();
         chk("abort_noacc", {30'd0, ramstate}, {30'd0, FREE});
         chk("abort_load", load, load_exp);
      end else begin
         addr = 32'h18;
         tick();
         for (int i = 0; i < LAT; i++) begin
            chk("restart_busy", {30'd0, ramstate}, {30'd0, BUSY});
            tick();
         end
         load_exp = model_mem[6];
         rd_n++;
         chk("restart_access", {30'd0, ramstate}, {30'd0, ACCESS});
         chk("restart_load", load, load_exp);
         ren = 1'b0;
         tick();
         chk("restart_free", {30'd0, ramstate}, {30'd0, FREE});
      end
   endtask

   initial begin
      nRST = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'd0; store = 32'd0;
      #3;
      chk("rst_state", {30'd0, ramstate}, {30'd0, FREE});
      chk("rst_load", load, 32'd0);
`ifdef RAM_RESPONDER_PERF_EN
      chk("rst_rd_cnt", rd_cnt, 32'd0);
      chk("rst_wr_cnt", wr_cnt, 32'd0);
      chk("rst_abort_cnt", {16'd0, abort_cnt}, 32'd0);
`endif
      tick();
      nRST = 1'b1;
      tick();
      chk("idle_free", {30'd0, ramstate}, {30'd0, FREE});

      // Fill the low 64 words so every later read has a known model value.
      for (int i = 0; i < 64; i++) xact(1'b0, 1'b1, 32'(i) << 2, $urandom);

      // Directed: preload then read word 5.
      xact(1'b0, 1'b1, 32'h14, 32'hDEADBEEF);
      xact(1'b1, 1'b0, 32'h14, 32'd0);
      chk("t1_value", load_exp, 32'hDEADBEEF);
      // Write then read back.
      xact(1'b0, 1'b1, 32'h20, 32'h12345678);
      xact(1'b1, 1'b0, 32'h20, 32'd0);
      chk("t2_load", load, 32'h12345678);
      // Illegal requests leave memory and load untouched.
      xact(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
      xact(1'b1, 1'b0, 32'h2, 32'd0);
      xact(1'b1, 1'b0, 32'h1000, 32'd0);
      xact(1'b0, 1'b1, 32'h1, 32'hCAFEF00D);
      xact(1'b1, 1'b0, 32'h0, 32'd0);
      // Held read across DONE exit: one FREE turnaround then re-sampled.
      ren = 1'b1; addr = 32'h14;
      tick();
      for (int i = 0; i < LAT; i++) tick();
      load_exp = model_mem[5];
      rd_n++;
      chk("held_access", {30'd0, ramstate}, {30'd0, ACCESS});
      tick();
      chk("held_turnaround", {30'd0, ramstate}, {30'd0, FREE});
      tick();
      chk("held_resample", {30'd0, ramstate}, {30'd0, BUSY});
      for (int i = 1; i < LAT; i++) tick();
      tick();
      rd_n++;
      chk("held_access2", {30'd0, ramstate}, {30'd0, ACCESS});
      chk("held_load2", load, load_exp);
      ren = 1'b0;
      tick();

      midop(1'b0);
      midop(1'b1);

      // Async reset in the second BUSY cycle of a write discards it.
      wen = 1'b1; addr = 32'h40; store = 32'hA5A5A5A5;
      tick();
      chk("rw_busy1", {30'd0, ramstate}, {30'd0, BUSY});
      tick();
      chk("rw_busy2", {30'd0, ramstate}, {30'd0, BUSY});
      #2 nRST = 1'b0;
      #1;
      chk("async_rst_state", {30'd0, ramstate}, {30'd0, FREE});
      chk("async_rst_load", load, 32'd0);
      load_exp = 32'd0; rd_n = 0; wr_n = 0; ab_n = 0;
      wen = 1'b0;
      tick();
      nRST = 1'b1;
      tick();
      xact(1'b1, 1'b0, 32'h40, 32'd0);
      chk("rw_old_data_kept", {31'd0, load == 32'hA5A5A5A5}, 32'd0);

      // Perf scenario: 3 reads, 2 writes, 1 abort, 1 error.
      xact(1'b1, 1'b0, 32'h8, 32'd0);
      xact(1'b0, 1'b1, 32'hC, $urandom);
      xact(1'b0, 1'b1, 32'h10, $urandom);
      xact(1'b1, 1'b0, 32'hC, 32'd0);
      midop(1'b1);
      xact(1'b1, 1'b0, 32'h3, 32'd0);
`ifdef RAM_RESPONDER_PERF_EN
      chk("perf_rd", rd_cnt, 32'(rd_n));
      chk("perf_wr", wr_cnt, 32'(wr_n));
      chk("perf_abort", {16'd0, abort_cnt}, 32'(ab_n));
`endif

      // Randomized mix of reads, writes and illegal requests.
      for (int n = 0; n < 80; n++) begin
         int k;
         k = int'($urandom_range(0, 9));
         if (k == 0) begin
            case ($urandom_range(0, 2))
               0:       xact(1'b1, 1'b1, 32'($urandom_range(0, 63)) << 2, $urandom);
               1:       xact(1'b1, 1'b0, (32'($urandom_range(0, 63)) << 2) | 32'd1, 32'd0);
               default: xact(1'b0, 1'b1, 32'($urandom_range(DEPTH, 4095)) << 2, $urandom);
            endcase
         end else if (k < 5) begin
            xact(1'b1, 1'b0, 32'($urandom_range(0, 63)) << 2, 32'd0);
         end else begin
            xact(1'b0, 1'b1, 32'($urandom_range(0, 63)) << 2, $urandom);
         end
      end
`ifdef RAM_RESPONDER_PERF_EN
      chk("perf_rd_end", rd_cnt, 32'(rd_n));
      chk("perf_wr_end", wr_cnt, 32'(wr_n));
      chk("perf_abort_end", {16'd0, abort_cnt}, 32'(ab_n));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
